// File: rtl/skl_pkg.sv
// rtl/skl_pkg.sv - shared constants and FSM encoding for the block-serial Sklansky adder
package skl_pkg;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    // Counter value of the final chunk, sized to match the 2-bit chunk counter.
    localparam logic [1:0] K_LAST = 2'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/skl8.sv
// rtl/skl8.sv - 8-bit Sklansky parallel-prefix adder with carry-in and carry-out
module skl8 (
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [7:0] p_bit;
    logic [7:0] g_grp;
    logic [7:0] p_grp;

    assign p_bit = x1 ^ x2;

    // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
    always_comb begin
        g_grp    = x1 & x2;
        p_grp    = p_bit;
        g_grp[0] = g_grp[0] | (p_grp[0] & cin);
        for (int l = 0; l < 3; l++) begin
            for (int i = 0; i < 8; i++) begin
                if (((i >> l) & 1) == 1) begin
                    int j;
                    j        = ((i >> l) << l) - 1;
                    g_grp[i] = g_grp[i] | (p_grp[i] & g_grp[j]);
                    p_grp[i] = p_grp[i] & p_grp[j];
                end
            end
        end
    end

    assign s    = p_bit ^ {g_grp[6:0], cin};
    assign cout = g_grp[7];

endmodule

// File: rtl/skl_32_seq_8.sv
// rtl/skl_32_seq_8.sv - 32-bit adder reusing one skl8 over four cycles with a registered carry
module skl_32_seq_8
    import skl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x1,
    input  logic [WIDTH-1:0]  x2,
    input  logic              cin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  s,
    output logic              cout
);

    state_t             state_q, state_d;
    logic [1:0]         k_q, k_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               cout_q, cout_d;

    logic [CHUNK-1:0]   sum8;
    logic               cout8;
    logic [4:0]         base;
    logic               accept;

    assign base = {k_q, 3'b000};

    skl8 u_skl8 (
        .x1   (a_q[base +: CHUNK]),
        .x2   (b_q[base +: CHUNK]),
        .cin  (carry_q),
        .s    (sum8),
        .cout (cout8)
    );

    // The unused encoding 2'd3 behaves as IDLE, so it can always accept.
    assign in_ready  = !rst && ((state_q != ST_RUN && state_q != ST_DONE) ||
                                (state_q == ST_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign cout      = cout_q;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            ST_RUN: begin
                s_d[base +: CHUNK] = sum8;
                carry_d            = cout8;
                k_d                = k_q + 2'd1;
                if (k_q == K_LAST) begin
                    cout_d  = cout8;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready && !in_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
        // Acceptance overrides everything else, including a same-edge DONE handoff.
        if (accept) begin
            a_d     = x1;
            b_d     = x2;
            carry_d = cin;
            k_d     = 2'd0;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

endmodule

// File: tb/tb_skl_32_seq_8.sv
// tb/tb_skl_32_seq_8.sv - randomized self-checking bench for skl_32_seq_8 against a transaction model
module tb_skl_32_seq_8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: cycles left until a result, whether one is held, its value.
    int          m_left;
    bit          m_valid;
    bit          m_hold;
    logic [32:0] m_res;
    logic [32:0] m_pend;
    int          pops;
    int          accepts;

    always #5 clk = ~clk;

    skl_32_seq_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x1        (x1),
        .x2        (x2),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check readiness, clock, advance the model, check outputs.
    task automatic step(input logic iv, input logic [31:0] a, input logic [31:0] b,
                        input logic c, input logic ordy, input logic r);
        bit exp_ready;
        bit acc;
        bit pop;
        rst       = r;
        in_valid  = iv;
        x1        = a;
        x2        = b;
        cin       = c;
        out_ready = ordy;
        #1;
        exp_ready = !r && ((m_left == 0 && !m_valid) || (m_valid && ordy));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        acc = iv && exp_ready;
        pop = m_valid && ordy && !r;
        @(posedge clk);
        if (r) begin
            m_left  = 0;
            m_valid = 0;
            m_hold  = 1;
            m_res   = '0;
        end else begin
            if (pop) begin
                m_valid = 0;
                pops++;
            end
            if (m_left > 0) begin
                if (m_left == 4) m_hold = 0;
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1;
                    m_hold  = 1;
                    m_res   = m_pend;
                end
            end
            if (acc) begin
                m_left = 4;
                m_pend = {1'b0, a} + {1'b0, b} + 33'(c);
                accepts++;
            end
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        if (m_valid || m_hold) chk("sum", 64'({cout, s}), 64'(m_res));
    endtask

    task automatic idle_cycles(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, $urandom, $urandom, 1'($urandom), ordy, 1'b0);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        case ($urandom_range(0, 5))
            0:       w = 32'hFFFF_FFFF;
            1:       w = 32'h0;
            2:       w = 32'h0000_00FF << (8 * $urandom_range(0, 3));
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        m_left = 0; m_valid = 0; m_hold = 0; m_res = '0; m_pend = '0;
        pops = 0; accepts = 0;

        // Reset with in_valid high: nothing may be accepted.
        step(1'b1, 32'h5, 32'h6, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h5, 32'h6, 1'b0, 1'b0, 1'b1);
        chk("rst_s", 64'(s), 64'h0);
        chk("rst_cout", 64'(cout), 64'h0);

        // Full carry propagation wrap.
        step(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        chk("wrap_s", 64'(s), 64'h0);
        chk("wrap_cout", 64'(cout), 64'h1);
        idle_cycles(1, 1'b1);

        // Mixed inter-chunk carries.
        step(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        idle_cycles(4, 1'b0);
        chk("mix_s", 64'(s), 64'hACF1_3568);
        chk("mix_cout", 64'(cout), 64'h0);

        // Backpressure with toggling operands, then a same-edge handoff.
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 32'h1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        chk("bp_busy", 64'(out_valid), 64'h0);
        idle_cycles(3, 1'b0);
        chk("bp_pending", 64'(out_valid), 64'h0);
        idle_cycles(1, 1'b0);
        chk("bp_s", 64'(s), 64'h0);
        chk("bp_cout", 64'(cout), 64'h1);
        idle_cycles(1, 1'b1);

        // Reset during the second RUN cycle aborts the operation.
        step(1'b1, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0);
        idle_cycles(1, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk("abort_s", 64'(s), 64'h0);
        idle_cycles(6, 1'b1);

        // Random traffic.
        begin
            int cyc = 0;
            while (pops < 2005 && cyc < 40000) begin
                step(1'($urandom_range(0, 9) < 7), rnd_word(), rnd_word(), 1'($urandom),
                     1'($urandom_range(0, 9) < 6), 1'b0);
                cyc++;
            end
            chk("rand_done", 64'(pops >= 2005), 64'h1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
